// File: rtl/vector_checker_pkg.sv
// Shared types and default sizing for the vector checker.
package vector_checker_pkg;

  localparam int N_DEF     = 3;
  localparam int W_DEF     = 1;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/vector_checker_if.sv
// Vector handshake between a stimulus source (master) and the checker (slave).
interface vector_checker_if
  import vector_checker_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
);

  logic             vec_valid;
  logic             vec_last;
  logic             vec_ready;
  logic [W-1:0]     y_exp;
  logic [N*W-1:0]   y_dut;

  modport master (output vec_valid, vec_last, y_exp, y_dut, input vec_ready);
  modport slave  (input vec_valid, vec_last, y_exp, y_dut, output vec_ready);

endinterface

// File: rtl/vector_checker_mismatch_popcount.sv
// Combinational count of set bits in an N-bit mismatch mask.
module mismatch_popcount #(
  parameter int N  = 3,
  parameter int PW = $clog2(N + 1)
) (
  input  logic [N-1:0]  mismatch,
  output logic [PW-1:0] count
);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + PW'(mismatch[i]);
    end
  end

endmodule

// File: rtl/vector_checker.sv
// Compares N DUT result slices against an expected value per vector and keeps run statistics.
// Optional first-error capture enabled by defining VECTOR_CHECKER_FIRST_ERR_EN.
module vector_checker
  import vector_checker_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              tick,
  input  logic              reset,
  input  logic              start,
  vector_checker_if.slave   vec,
  output logic              err_pulse,
  output logic [N-1:0]      err_mask,
  output logic [CNT_W-1:0]  vector_count,
  output logic [CNT_W-1:0]  error_count,
  output logic              busy,
  output logic              done,
  output logic              pass
`ifdef VECTOR_CHECKER_FIRST_ERR_EN
  ,
  output logic [CNT_W-1:0]  first_err_index,
  output logic [N-1:0]      first_err_mask
`endif
);

  localparam int              PW      = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic              accept;
  logic              clear;
  logic [N-1:0]      mismatch;
  logic [PW-1:0]     pop;
  logic [CNT_W:0]    err_sum;
  logic [CNT_W-1:0]  vec_next;
  logic [CNT_W-1:0]  err_next;

  assign accept = (state_q == RUN) && vec.vec_valid;
  // start only restarts from IDLE or DONE; a start during RUN is ignored.
  assign clear  = start && (state_q != RUN);

  always_comb begin
    mismatch = '0;
    for (int i = 0; i < N; i++) begin
      mismatch[i] = (vec.y_dut[i*W +: W] != vec.y_exp);
    end
  end

  mismatch_popcount #(.N(N), .PW(PW)) u_popcount (
    .mismatch (mismatch),
    .count    (pop)
  );

  // Saturating counter updates; the extra sum bit flags overflow.
  assign vec_next = (vector_count == CNT_MAX) ? vector_count : vector_count + CNT_W'(1);
  assign err_sum  = {1'b0, error_count} + (CNT_W + 1)'(pop);
  assign err_next = err_sum[CNT_W] ? CNT_MAX : err_sum[CNT_W-1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && vec.vec_last) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge tick) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge tick) begin
    if (reset || clear) begin
      err_pulse    <= 1'b0;
      err_mask     <= '0;
      vector_count <= '0;
      error_count  <= '0;
    end else begin
      err_pulse <= accept && (|mismatch);
      if (accept) begin
        err_mask     <= mismatch;
        vector_count <= vec_next;
        error_count  <= err_next;
      end
    end
  end

`ifdef VECTOR_CHECKER_FIRST_ERR_EN
  // A captured mask is never zero, so a zero mask means no mismatch seen yet this run.
  always_ff @(posedge tick) begin
    if (reset || clear) begin
      first_err_index <= '0;
      first_err_mask  <= '0;
    end else if (accept && (|mismatch) && (first_err_mask == '0)) begin
      first_err_index <= vec_next;
      first_err_mask  <= mismatch;
    end
  end
`endif

  assign busy          = (state_q == RUN);
  assign vec.vec_ready = busy;
  assign done          = (state_q == DONE);
  assign pass          = done && (error_count == '0);

endmodule

// File: tb/tb_vector_checker.sv
// Directed bench for vector_checker: default instance plus a CNT_W=3 instance for saturation.
module tb_vector_checker;

  logic tick = 1'b0;
  logic reset;
  logic start;
  logic sat_start;

  always #5 tick = ~tick;

  vector_checker_if #(.N(3), .W(1)) vif ();
  vector_checker_if #(.N(3), .W(1)) sif ();

  logic        err_pulse, busy, done, pass;
  logic [2:0]  err_mask;
  logic [31:0] vector_count, error_count;

  logic        s_err_pulse, s_busy, s_done, s_pass;
  logic [2:0]  s_err_mask;
  logic [2:0]  s_vector_count, s_error_count;

`ifdef VECTOR_CHECKER_FIRST_ERR_EN
  logic [31:0] first_err_index;
  logic [2:0]  first_err_mask;
  logic [2:0]  s_first_err_index;
  logic [2:0]  s_first_err_mask;
`endif

  vector_checker #(.N(3), .W(1), .CNT_W(32)) u_dut (
    .tick         (tick),
    .reset        (reset),
    .start        (start),
    .vec          (vif),
    .err_pulse    (err_pulse),
    .err_mask     (err_mask),
    .vector_count (vector_count),
    .error_count  (error_count),
    .busy         (busy),
    .done         (done),
    .pass         (pass)
`ifdef VECTOR_CHECKER_FIRST_ERR_EN
    ,
    .first_err_index (first_err_index),
    .first_err_mask  (first_err_mask)
`endif
  );

  vector_checker #(.N(3), .W(1), .CNT_W(3)) u_sat (
    .tick         (tick),
    .reset        (reset),
    .start        (sat_start),
    .vec          (sif),
    .err_pulse    (s_err_pulse),
    .err_mask     (s_err_mask),
    .vector_count (s_vector_count),
    .error_count  (s_error_count),
    .busy         (s_busy),
    .done         (s_done),
    .pass         (s_pass)
`ifdef VECTOR_CHECKER_FIRST_ERR_EN
    ,
    .first_err_index (s_first_err_index),
    .first_err_mask  (s_first_err_mask)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge tick);
    #1;
  endtask

  task automatic drive(input logic valid, input logic last, input logic y_exp, input logic [2:0] y_dut);
    vif.vec_valid = valid;
    vif.vec_last  = last;
    vif.y_exp     = y_exp;
    vif.y_dut     = y_dut;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    sat_start = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000);
    sif.vec_valid = 1'b0;
    sif.vec_last  = 1'b0;
    sif.y_exp     = 1'b0;
    sif.y_dut     = 3'b000;
    step();
    step();
    reset = 1'b0;

    check("rst_busy",  busy, 0);
    check("rst_ready", vif.vec_ready, 0);
    check("rst_done",  done, 0);
    check("rst_pass",  pass, 0);
    check("rst_vc",    vector_count, 0);
    check("rst_ec",    error_count, 0);
    check("rst_mask",  err_mask, 0);
    check("rst_pulse", err_pulse, 0);

    // Inverter truth table, all three implementations correct.
    pulse_start();
    check("run_busy",  busy, 1);
    check("run_ready", vif.vec_ready, 1);
    drive(1'b1, 1'b0, 1'b1, 3'b111);
    step();
    check("inv1_vc",    vector_count, 1);
    check("inv1_pulse", err_pulse, 0);
    drive(1'b1, 1'b1, 1'b0, 3'b000);
    step();
    drive(1'b0, 1'b0, 1'b0, 3'b000);
    check("inv_vc",    vector_count, 2);
    check("inv_ec",    error_count, 0);
    check("inv_done",  done, 1);
    check("inv_pass",  pass, 1);
    check("inv_busy",  busy, 0);
    check("inv_ready", vif.vec_ready, 0);

    // Single wrong slice in the middle implementation.
    pulse_start();
    check("mm_clr_vc", vector_count, 0);
    check("mm_busy",   busy, 1);
    drive(1'b1, 1'b1, 1'b1, 3'b101);
    step();
    drive(1'b0, 1'b0, 1'b0, 3'b000);
    check("mm_mask",  err_mask, 3'b010);
    check("mm_pulse", err_pulse, 1);
    check("mm_ec",    error_count, 1);
    check("mm_done",  done, 1);
    check("mm_pass",  pass, 0);
    step();
    check("mm_pulse_off", err_pulse, 0);
    check("mm_mask_hold", err_mask, 3'b010);
    check("mm_ec_hold",   error_count, 1);

    // Idle RUN: no valid, stray vec_last, then start ignored.
    pulse_start();
    drive(1'b1, 1'b0, 1'b0, 3'b000);
    step();
    check("idle_vc0", vector_count, 1);
    drive(1'b0, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 5; i++) begin
      vif.vec_last = (i == 2);
      step();
    end
    vif.vec_last = 1'b0;
    pulse_start();
    check("idle_busy", busy, 1);
    check("idle_done", done, 0);
    check("idle_vc",   vector_count, 1);
    check("idle_ec",   error_count, 0);

    // Two more vectors, then reset together with start and valid.
    drive(1'b1, 1'b0, 1'b1, 3'b111);
    step();
    drive(1'b1, 1'b0, 1'b0, 3'b110);
    step();
    check("pre_rst_vc", vector_count, 3);
    check("pre_rst_ec", error_count, 2);
    reset = 1'b1;
    start = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 3'b111);
    step();
    reset = 1'b0;
    start = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000);
    check("mid_rst_busy",  busy, 0);
    check("mid_rst_done",  done, 0);
    check("mid_rst_pass",  pass, 0);
    check("mid_rst_vc",    vector_count, 0);
    check("mid_rst_ec",    error_count, 0);
    check("mid_rst_mask",  err_mask, 0);
    check("mid_rst_pulse", err_pulse, 0);
    step();
    check("rst_stay_idle", busy, 0);
    pulse_start();
    check("fresh_vc0", vector_count, 0);
    drive(1'b1, 1'b1, 1'b0, 3'b001);
    step();
    drive(1'b0, 1'b0, 1'b0, 3'b000);
    check("fresh_vc",   vector_count, 1);
    check("fresh_ec",   error_count, 1);
    check("fresh_mask", err_mask, 3'b001);
    check("fresh_done", done, 1);

`ifdef VECTOR_CHECKER_FIRST_ERR_EN
    check("fe_after_run_idx", first_err_index, 1);
    pulse_start();
    check("fe_clr_idx",  first_err_index, 0);
    check("fe_clr_mask", first_err_mask, 0);
    for (int k = 1; k <= 6; k++) begin
      logic [2:0] y;
      y = (k == 4) ? 3'b011 : (k == 6) ? 3'b100 : 3'b111;
      drive(1'b1, (k == 6), 1'b1, y);
      step();
      if (k == 3) check("fe_none_idx", first_err_index, 0);
    end
    drive(1'b0, 1'b0, 1'b0, 3'b000);
    check("fe_idx",  first_err_index, 4);
    check("fe_mask", first_err_mask, 3'b100);
    check("fe_done", done, 1);
    step();
    check("fe_idx_hold",  first_err_index, 4);
    check("fe_mask_hold", first_err_mask, 3'b100);
`endif

    // Saturation on the 3-bit counter instance: every slice wrong, 9 vectors.
    sat_start = 1'b1;
    step();
    sat_start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      int exp_vc, exp_ec;
      sif.vec_valid = 1'b1;
      sif.vec_last  = (k == 9);
      sif.y_exp     = 1'b0;
      sif.y_dut     = 3'b111;
      step();
      exp_vc = (k > 7) ? 7 : k;
      exp_ec = (3 * k > 7) ? 7 : 3 * k;
      check($sformatf("sat_vc_%0d", k), s_vector_count, exp_vc);
      check($sformatf("sat_ec_%0d", k), s_error_count, exp_ec);
    end
    sif.vec_valid = 1'b0;
    sif.vec_last  = 1'b0;
    check("sat_done", s_done, 1);
    check("sat_pass", s_pass, 0);
    step();
    step();
    check("sat_vc_hold", s_vector_count, 7);
    check("sat_ec_hold", s_error_count, 7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vector_checker.md
VECTOR_CHECKER -- requirements
Module: vector_checker

Interface
REQ-001 Parameter N, default 3: number of DUT implementations compared (gate, dataflow, behavioral).
REQ-002 Parameter W, default 1: result width per implementation.
REQ-003 Parameter CNT_W, default 32: width of vector and error counters.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 tick  in  1  clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 start  in  1  begin a new check run.
REQ-008 vec_valid  in  1  y_exp and y_dut hold a vector to be checked.
REQ-009 vec_last  in  1  the current vector is the final one of the run.
REQ-010 y_exp  in  W  expected result.
REQ-011 y_dut  in  N*W  DUT results; slice i is [i*W +: W].
REQ-012 vec_ready  out  1  checker accepts a vector this cycle.
REQ-013 err_pulse  out  1  one-cycle flag: the last accepted vector had a mismatch.
REQ-014 err_mask  out  N  per-implementation mismatch flags of the last accepted vector.
REQ-015 vector_count  out  CNT_W  vectors accepted in the current run.
REQ-016 error_count  out  CNT_W  mismatches accumulated in the current run.
REQ-017 busy, done, pass  out  1 each  run active; run finished; finished with zero errors.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-019 IDLE: start moves to RUN, clearing both counters, err_mask and err_pulse on the same edge.
REQ-020 RUN: vec_ready SHALL be 1; a vector SHALL be accepted when vec_valid and vec_ready are both 1.
REQ-021 On accept, err_mask[i] SHALL be set to (y_dut slice i != y_exp), registered, one cycle latency.
REQ-022 On accept, vector_count SHALL increment by 1, and error_count SHALL increment by popcount(mismatches), 0..N.
REQ-023 err_pulse SHALL be 1 only for the cycle following an accept with a nonzero mismatch mask.
REQ-024 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 An accept with vec_last=1 SHALL move to DONE on the same edge; vec_ready SHALL be 0 in DONE.
REQ-026 vec_last without vec_valid SHALL be ignored.
REQ-027 DONE: done=1, pass=(error_count==0); counters SHALL hold; start SHALL re-enter RUN with counters cleared.
REQ-028 start asserted in RUN SHALL be ignored.
REQ-029 busy SHALL be 1 exactly in RUN; vec_ready SHALL equal busy.

Reset
REQ-030 reset SHALL force IDLE and zero every output and counter on the next edge, including mid-run.
REQ-031 reset SHALL take priority over start and vec_valid in the same cycle.

Configuration
REQ-032 Macro VECTOR_CHECKER_FIRST_ERR_EN defined: add outputs first_err_index (CNT_W) and first_err_mask (N).
REQ-033 When enabled, these outputs SHALL latch the 1-based vector index and mask of the first mismatching vector of a run.
REQ-034 When enabled, they SHALL be cleared by reset and by start, and SHALL hold after the first mismatch.
REQ-035 Macro undefined: these ports and their logic SHALL be absent, with behaviour otherwise identical.

Structure
REQ-036 Package vector_checker_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the default N, W and CNT_W constants.
REQ-037 Sub-module mismatch_popcount SHALL compute the N-bit mismatch count combinationally.

Verification
REQ-038 N=3, W=1, 2 vectors, inverter truth table (a=0→1, a=1→0), all DUT outputs correct, second marked last -> vector_count=2, error_count=0, done=1, pass=1.
REQ-039 Vector y_exp=1, y_dut=3'b101 (slice 1 wrong) -> err_mask=3'b010, err_pulse for 1 cycle, error_count+=1, pass=0 at DONE.
REQ-040 CNT_W=3, 9 vectors with all slices wrong -> error_count=7 and vector_count=7, both saturated and held.
REQ-041 reset asserted after 3 accepted vectors -> IDLE next edge, all outputs 0; a later start runs a fresh count from 0.
REQ-042 vec_valid held low for 5 cycles in RUN, then start pulsed -> counters unchanged, state remains RUN.
REQ-043 With VECTOR_CHECKER_FIRST_ERR_EN, mismatches on vectors 4 and 6 -> first_err_index=4 and first_err_mask from vector 4, held through DONE.
